// File: rtl/data_mem_ctrl.sv
// Byte-addressed MIPS-32 data memory with lane-accurate stores, extended loads,
// a valid/ready request port, one-cycle registered responses and a reset-time clearing sweep.
module data_mem_ctrl #(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int TOP_BIT = IDX_W + 2;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mem [DEPTH];

    logic               op_ok;
    logic               is_store;
    logic               sign_ext;
    size_e              size;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         off;
    logic [ADDR_W-1:0]  high_bits;
    logic               out_of_range;
    logic               misaligned;
    logic               bad;
    logic               accept;
    logic               clr_we;
    logic               st_we;
    logic [3:0]         be;
    logic [31:0]        lane;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_val;

    // ---------------------------------------------------------------- decode
    // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        op_ok    = 1'b1;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SZ_WORD;
        case (opcode)
            OP_LB:   begin size = SZ_BYTE; sign_ext = 1'b1; end
            OP_LH:   begin size = SZ_HALF; sign_ext = 1'b1; end
            OP_LW:   size = SZ_WORD;
            OP_LBU:  size = SZ_BYTE;
            OP_LHU:  size = SZ_HALF;
            OP_SB:   begin size = SZ_BYTE; is_store = 1'b1; end
            OP_SH:   begin size = SZ_HALF; is_store = 1'b1; end
            OP_SW:   begin size = SZ_WORD; is_store = 1'b1; end
            default: op_ok = 1'b0;
        endcase
    end

    assign word_idx  = addr[IDX_W+1:2];
    assign off       = addr[1:0];
    // Everything above the word index must be zero, otherwise the access aliases outside the array.
    assign high_bits    = addr >> TOP_BIT;
    assign out_of_range = |high_bits;
    assign misaligned   = ((size == SZ_HALF) && addr[0]) ||
                          ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign bad          = out_of_range || misaligned;

    assign req_ready = (state_q == ST_READY) && !rst;
    assign accept    = req_valid && req_ready && op_ok;
    assign clr_we    = (state_q == ST_CLEAR) && !rst;
    assign st_we     = accept && is_store && !bad;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    // ---------------------------------------------------------------- store lanes
    always_comb begin
        be   = 4'b0000;
        lane = wdata;
        case (size)
            SZ_BYTE: begin
                be   = 4'b0001 << off;
                lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be   = off[1] ? 4'b1100 : 4'b0011;
                lane = {2{wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                lane = wdata;
            end
        endcase
    end

    // NOTE: the array has no reset; clearing is done by the post-reset sweep so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (st_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= lane[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- load extract
    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{off, 3'b000} +: 8];
    assign rd_half = rd_word[{off[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        case (size)
            SZ_BYTE: load_val = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            SZ_HALF: load_val = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // ---------------------------------------------------------------- response
    // Store responses and errors carry zero data; rdata/err idle at zero between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= accept;
            err        <= accept && bad;
            rdata      <= (accept && !is_store && !bad) ? load_val : '0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-array reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_W(32),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .opcode(opcode),
        .addr(addr),
        .wdata(wdata),
        .resp_valid(resp_valid),
        .rdata(rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    logic [7:0]  mem_b [DEPTH*4];
    int          sweep_left = 0;
    bit          seeded     = 1'b0;
    logic        exp_valid  = 1'b0;
    logic [31:0] exp_rdata  = '0;
    logic        exp_err    = 1'b0;

    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
        logic signed [7:0]  sb8;
        logic signed [15:0] sh16;
        int                 v;
        sb8  = mem_b[a];
        sh16 = {mem_b[a+1], mem_b[a]};
        case (op)
            LB:      v = sb8;
            LBU:     v = int'(mem_b[a]);
            LH:      v = sh16;
            LHU:     v = int'({mem_b[a+1], mem_b[a]});
            default: v = {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        int  nb;
        bit  acc;
        bit  bad;
        if (rst) begin
            seeded     = 1'b1;
            sweep_left = DEPTH;
            exp_valid  = 1'b0;
            exp_rdata  = '0;
            exp_err    = 1'b0;
            for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;
        end else if (seeded) begin
            nb  = op_bytes(opcode);
            acc = req_valid && (sweep_left == 0) && (nb != 0);
            bad = (nb != 0) && (((addr % nb) != 0) || (addr >= 32'(DEPTH*4)));
            exp_valid = acc;
            exp_rdata = '0;
            exp_err   = 1'b0;
            if (acc) begin
                if (bad) exp_err = 1'b1;
                else if (op_is_store(opcode))
                    for (int k = 0; k < nb; k++) mem_b[addr+k] = wdata[8*k +: 8];
                else exp_rdata = model_load(opcode, addr);
            end
            if (sweep_left > 0) sweep_left--;
        end
    end

    // ---------------------------------------------------------------- per-cycle compare
    always @(posedge clk) begin
        #1;
        if (seeded) begin
            check("req_ready",  {31'b0, req_ready},  {31'b0, (sweep_left == 0) && !rst});
            check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
            check("rdata",      rdata,               exp_rdata);
            check("err",        {31'b0, err},        {31'b0, exp_err});
        end
    end

    // ---------------------------------------------------------------- directed stimulus
    task automatic req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        wdata     = d;
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        opcode    = 6'b0;
        addr      = '0;
        wdata     = '0;
        @(negedge clk);
    endtask

    task automatic expect_resp(input string name, input logic [31:0] want_rdata, input logic want_err);
        check({name, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, "_rdata"}, rdata, want_rdata);
        check({name, "_err"},   {31'b0, err}, {31'b0, want_err});
    endtask

    task automatic sweep_count(input string name);
        int n = 0;
        while (!req_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check(name, n, DEPTH);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        opcode = '0;
        addr = '0;
        wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'd0);
        check("reset_resp",  {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        sweep_count("sweep_len");

        req(LW, 32'h3FC, '0);            expect_resp("lw_3fc_cleared", 32'h0000_0000, 1'b0);

        req(SW, 32'h0, 32'h80FF7F01);    expect_resp("sw_0", 32'h0, 1'b0);
        req(SB, 32'h2, 32'h000000AA);    expect_resp("sb_2", 32'h0, 1'b0);
        req(LW, 32'h0, '0);              expect_resp("lw_0", 32'h80AA7F01, 1'b0);
        req(LB, 32'h3, '0);              expect_resp("lb_3", 32'hFFFFFF80, 1'b0);
        req(LBU, 32'h3, '0);             expect_resp("lbu_3", 32'h00000080, 1'b0);
        req(LH, 32'h2, '0);              expect_resp("lh_2", 32'hFFFF80AA, 1'b0);
        req(LHU, 32'h2, '0);             expect_resp("lhu_2", 32'h000080AA, 1'b0);
        req(LB, 32'h0, '0);              expect_resp("lb_0", 32'h00000001, 1'b0);
        req(LH, 32'h0, '0);              expect_resp("lh_0", 32'h00007F01, 1'b0);

        req(LW, 32'h6, '0);              expect_resp("err_lw_6", 32'h0, 1'b1);
        req(LH, 32'h1, '0);              expect_resp("err_lh_1", 32'h0, 1'b1);
        req(SH, 32'h3, 32'h1234);        expect_resp("err_sh_3", 32'h0, 1'b1);
        req(SW, 32'h400, 32'h5555AAAA);  expect_resp("err_sw_400", 32'h0, 1'b1);
        req(LW, 32'h0, '0);              expect_resp("word0_unchanged", 32'h80AA7F01, 1'b0);

        req(SH, 32'h6, 32'hFFFFC0DE);    expect_resp("sh_6", 32'h0, 1'b0);
        req(LW, 32'h4, '0);              expect_resp("lw_4_after_sh", 32'hC0DE0000, 1'b0);

        req(SW, 32'h10, 32'hDEADBEEF);   expect_resp("raw_sw", 32'h0, 1'b0);
        req(LW, 32'h10, '0);             expect_resp("raw_lw", 32'hDEADBEEF, 1'b0);
        idle();
        check("idle_after_raw", {31'b0, resp_valid}, 32'd0);
        check("idle_rdata_zero", rdata, 32'h0);

        req(6'b000000, 32'h0, 32'h12345678);
        check("ignored_op_no_resp", {31'b0, resp_valid}, 32'd0);
        req(LW, 32'h0, '0);              expect_resp("ignored_op_unchanged", 32'h80AA7F01, 1'b0);

        req(LW, 32'h10, '0);             expect_resp("pre_reset_lw", 32'hDEADBEEF, 1'b0);
        rst = 1'b1;
        req(LW, 32'h0, '0);
        check("reset_drops_resp", {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        idle_no_wait();
        sweep_count("sweep_restart_len");
        req(LW, 32'h10, '0);             expect_resp("after_reset_cleared", 32'h0, 1'b0);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic idle_no_wait();
        req_valid = 1'b0;
        opcode    = 6'b0;
        addr      = '0;
        wdata     = '0;
    endtask

endmodule
